// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx - serial UART transmitter with a small input FIFO.
//
// Upstream logic pushes words through a valid/ready port into a power-of-two
// FIFO. The shifter pops one word at a time and sends it LSB first as a frame:
// start bit (0), DATA_SIZE data bits, optional parity bit, STOP_BITS stop
// bits (1). Every bit lasts exactly CLK_BAUD_RATIO clk_in cycles.
// Back-to-back words go out with no idle gap between frames.
//
// Handshake: a word transfers on a rising clk_in edge where valid_in and
// ready_out are both high. ready_out is combinational (!full && !rst_in) and
// does not depend on valid_in. There is no push-to-pop bypass.
//
// Optional feature macro: TX_PARITY_EN
//   defined   -> a parity bit follows the MSB; even parity when PARITY_ODD=0
//                (bit = ^data), odd parity when PARITY_ODD=1 (bit = ~^data).
//   undefined -> no parity state or logic; PARITY_ODD is unused.
//
// Ports:
//   clk_in          in   1            system clock
//   rst_in          in   1            asynchronous active-high reset
//   data_in         in   DATA_SIZE    word to send, sampled only at push
//   valid_in        in   1            data_in valid
//   ready_out       out  1            FIFO can accept a word
//   tx_out          out  1            serial line, idle high, registered
//   busy_out        out  1            frame in progress or FIFO non-empty
//   fifo_count_out  out  CNT_W        words currently held in the FIFO
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int CLK_BAUD_RATIO = 25,
  parameter int DATA_SIZE      = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int STOP_BITS      = 1,
  parameter int PARITY_ODD     = 0
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [DATA_SIZE-1:0]             data_in,
  input  logic                             valid_in,
  output logic                             ready_out,
  output logic                             tx_out,
  output logic                             busy_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count_out
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLK_BAUD_RATIO);
  localparam int IDX_W  = $clog2(DATA_SIZE + 1);

  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_BAUD_RATIO - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_SIZE - 1);
  // Stop-bit index is one bit wide: 0 for the first stop bit, 1 for the second.
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

`ifdef TX_PARITY_EN
  localparam logic PAR_INV = 1'(PARITY_ODD);
`else
  // Parity disabled: the parameter is kept for interface compatibility only.
  localparam int unused_parity_odd = PARITY_ODD;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_SIZE-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     w_count_n;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [DATA_SIZE-1:0] w_fifo_rd;

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign ready_out = !w_full && !rst_in;
  assign w_push    = valid_in && ready_out;
  assign w_fifo_rd = r_mem[r_rd_ptr];

  // Storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_comb begin
    w_count_n = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_n = r_count + CNT_W'(1);
      2'b01:   w_count_n = r_count - CNT_W'(1);
      default: w_count_n = r_count;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_t               r_state,    w_state_n;
  logic [BAUD_W-1:0]    r_baud,     w_baud_n;
  logic [IDX_W-1:0]     r_idx,      w_idx_n;
  logic [DATA_SIZE-1:0] r_shift,    w_shift_n;
  logic                 r_stop_idx, w_stop_n;
  logic                 r_tx,       w_tx_n;
  logic                 r_busy,     w_busy_n;
  logic                 w_bit_end;
`ifdef TX_PARITY_EN
  logic                 r_par,      w_par_n;
`endif

  assign w_bit_end = (r_baud == BAUD_LAST);

  always_comb begin
    w_state_n = r_state;
    w_baud_n  = r_baud;
    w_idx_n   = r_idx;
    w_shift_n = r_shift;
    w_stop_n  = r_stop_idx;
    w_tx_n    = r_tx;
    w_pop     = 1'b0;
`ifdef TX_PARITY_EN
    w_par_n   = r_par;
`endif

    // The baud counter free-runs inside a frame and wraps at each bit end;
    // it sits at zero in IDLE so every frame starts from a clean count.
    if (r_state != S_IDLE) begin
      w_baud_n = w_bit_end ? '0 : r_baud + BAUD_W'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_state_n = S_START;
          w_tx_n    = 1'b0;
          w_baud_n  = '0;
          w_shift_n = w_fifo_rd;
`ifdef TX_PARITY_EN
          w_par_n   = (^w_fifo_rd) ^ PAR_INV;
`endif
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_state_n = S_DATA;
          w_tx_n    = r_shift[0];
          w_shift_n = r_shift >> 1;
          w_idx_n   = '0;
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          if (r_idx == IDX_LAST) begin
`ifdef TX_PARITY_EN
            w_state_n = S_PARITY;
            w_tx_n    = r_par;
`else
            w_state_n = S_STOP;
            w_tx_n    = 1'b1;
            w_stop_n  = 1'b0;
`endif
          end else begin
            w_tx_n    = r_shift[0];
            w_shift_n = r_shift >> 1;
            w_idx_n   = r_idx + IDX_W'(1);
          end
        end
      end

`ifdef TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_n = S_STOP;
          w_tx_n    = 1'b1;
          w_stop_n  = 1'b0;
        end
      end
`endif

      S_STOP: begin
        if (w_bit_end) begin
          if (r_stop_idx == STOP_LAST) begin
            // Last cycle of the last stop bit: chain straight into the
            // next frame when a word is waiting, so there is no idle gap.
            if (!w_empty) begin
              w_pop     = 1'b1;
              w_state_n = S_START;
              w_tx_n    = 1'b0;
              w_shift_n = w_fifo_rd;
`ifdef TX_PARITY_EN
              w_par_n   = (^w_fifo_rd) ^ PAR_INV;
`endif
            end else begin
              w_state_n = S_IDLE;
            end
          end else begin
            w_stop_n = 1'b1;
          end
        end
      end

      default: begin
        w_state_n = S_IDLE;
        w_tx_n    = 1'b1;
      end
    endcase

    w_busy_n = (w_state_n != S_IDLE) || (w_count_n != '0);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_stop_idx <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
`ifdef TX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_n;
      r_baud     <= w_baud_n;
      r_idx      <= w_idx_n;
      r_shift    <= w_shift_n;
      r_stop_idx <= w_stop_n;
      r_tx       <= w_tx_n;
      r_busy     <= w_busy_n;
`ifdef TX_PARITY_EN
      r_par      <= w_par_n;
`endif
    end
  end

  assign tx_out         = r_tx;
  assign busy_out       = r_busy;
  assign fifo_count_out = r_count;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx - self-checking bench for uart_tx (CLK_BAUD_RATIO=4, DATA_SIZE=8,
// FIFO_DEPTH=4, STOP_BITS=1, PARITY_ODD=0).
// A serial decoder watches tx_out and pops the expected word queue for every
// completed frame; directed steps check timing, flow control and reset.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int R  = 4;
  localparam int DW = 8;
  localparam int FD = 4;
  localparam int PODD = 0;
`ifdef TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME_BITS = 1 + DW + P + 1;
  localparam int FRAME_CYC  = FRAME_BITS * R;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          valid_in = 1'b0;
  logic          ready_out;
  logic          tx_out;
  logic          busy_out;
  logic [2:0]    fifo_count_out;

  always #5 clk_in = ~clk_in;

  uart_tx #(
    .CLK_BAUD_RATIO (R),
    .DATA_SIZE      (DW),
    .FIFO_DEPTH     (FD),
    .STOP_BITS      (1),
    .PARITY_ODD     (PODD)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .data_in        (data_in),
    .valid_in       (valid_in),
    .ready_out      (ready_out),
    .tx_out         (tx_out),
    .busy_out       (busy_out),
    .fifo_count_out (fifo_count_out)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and check helper
  // ---------------------------------------------------------------------------
  logic [DW-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int m_frames = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference frame model: bit b of a frame carrying word d.
  function automatic logic frame_bit(input logic [DW-1:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= DW) return d[b-1];
`ifdef TX_PARITY_EN
    if (b == DW + 1) return (^d) ^ 1'(PODD);
`endif
    return 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Serial decoder: samples each bit mid-way, compares against exp_q
  // ---------------------------------------------------------------------------
  logic          m_act = 1'b0;
  int            m_cnt = 0;
  logic [DW-1:0] m_word;
  logic          m_par;
  logic [DW-1:0] m_exp;

  initial begin
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        m_act = 1'b0;
      end else if (!m_act) begin
        if (tx_out === 1'b0) begin
          m_act = 1'b1;
          m_cnt = 0;
        end
      end else begin
        m_cnt++;
        if ((m_cnt % R) == (R / 2)) begin
          if (m_cnt / R == 0) begin
            check("sb_start_bit", tx_out, 0);
          end else if (m_cnt / R <= DW) begin
            m_word[m_cnt / R - 1] = tx_out;
          end else if (m_cnt / R < FRAME_BITS - 1) begin
            m_par = tx_out;
          end else begin
            check("sb_stop_bit", tx_out, 1);
            check("sb_queue_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              m_exp = exp_q.pop_front();
              check("sb_word", m_word, m_exp);
`ifdef TX_PARITY_EN
              check("sb_parity", m_par, (^m_exp) ^ 1'(PODD));
`endif
            end
            m_frames++;
            m_act = 1'b0;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a negedge; return at the next negedge)
  // ---------------------------------------------------------------------------
  task automatic push_word(input logic [DW-1:0] d);
    logic acc;
    data_in  = d;
    valid_in = 1'b1;
    acc      = ready_out;
    @(negedge clk_in);
    valid_in = 1'b0;
    data_in  = DW'($urandom_range(0, 255));
    if (acc) exp_q.push_back(d);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy_out !== 1'b0 && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    check({tag, "_idle"}, busy_out, 0);
  endtask

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  logic [DW-1:0] words [6];
  int            cyc;
  int            lows;
  int            sent;
  int            guard;
  int            frames0;
  logic          acc;
  logic [DW-1:0] cur;

  initial begin
    // Reset from power-up.
    #1 rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    check("rst_tx", tx_out, 1);
    check("rst_busy", busy_out, 0);
    check("rst_ready_held", ready_out, 0);
    check("rst_count", fifo_count_out, 0);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("rel_ready", ready_out, 1);
    check("rel_count", fifo_count_out, 0);

    // Single word 0xA5: exact waveform and busy release.
    push_word(8'hA5);
    check("a5_count", fifo_count_out, 1);
    check("a5_busy_set", busy_out, 1);
    for (int i = 0; i < FRAME_CYC; i++) begin
      @(negedge clk_in);
      check($sformatf("a5_cycle%0d", i + 1), tx_out, frame_bit(8'hA5, i / R));
    end
    check("a5_busy_last", busy_out, 1);
    @(negedge clk_in);
    check("a5_busy_clear", busy_out, 0);
    check("a5_tx_idle", tx_out, 1);

    // Burst of 6 pushes on consecutive edges: 5 accepted, 6th dropped.
    repeat (3) @(negedge clk_in);
    frames0 = m_frames;
    for (int i = 0; i < 6; i++) words[i] = DW'($urandom_range(0, 255));
    for (int i = 0; i < 5; i++) exp_q.push_back(words[i]);
    valid_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_in = words[i];
      @(negedge clk_in);
      if (i == 0) check("burst_tx_before_pop", tx_out, 1);
      if (i == 1) check("burst_first_start", tx_out, 0);
      if (i == 4) begin
        check("burst_full_count", fifo_count_out, 4);
        check("burst_full_ready", ready_out, 0);
      end
    end
    valid_in = 1'b0;
    data_in  = 8'h00;
    check("burst_after_drop_count", fifo_count_out, 4);
    cyc = 5;
    while (busy_out === 1'b1 && cyc < 1000) begin
      @(negedge clk_in);
      cyc++;
    end
    check("burst_busy_fall_edge", cyc, 5 * FRAME_CYC + 1);
    check("burst_frames", m_frames - frames0, 5);
    check("burst_queue_drained", exp_q.size(), 0);

    // Asynchronous reset in the middle of data bit 3 of 0xFF, two words queued.
    repeat (3) @(negedge clk_in);
    push_word(8'hFF);
    push_word(8'h3C);
    push_word(8'h81);
    repeat (16) @(negedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    check("arst_tx", tx_out, 1);
    check("arst_busy", busy_out, 0);
    check("arst_count", fifo_count_out, 0);
    check("arst_ready", ready_out, 0);
    exp_q.delete();
    @(negedge clk_in);
    check("arst_ready_held", ready_out, 0);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("arst_rel_ready", ready_out, 1);
    check("arst_rel_count", fifo_count_out, 0);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      if (tx_out !== 1'b1) lows++;
    end
    check("arst_quiet_line", lows, 0);
    check("arst_quiet_busy", busy_out, 0);

    // Frame length (parity bit present only when the feature is built in).
    push_word(8'h07);
    repeat (39) @(negedge clk_in);
`ifdef TX_PARITY_EN
    check("p07_parity_bit", tx_out, 1);
`else
    check("p07_stop_bit", tx_out, 1);
`endif
    cyc = 39;
    while (busy_out === 1'b1 && cyc < 1000) begin
      @(negedge clk_in);
      cyc++;
    end
    check("p07_frame_len", cyc - 1, FRAME_CYC);

    // 256 random words at full rate through the serial decoder.
    repeat (2) @(negedge clk_in);
    frames0 = m_frames;
    sent  = 0;
    guard = 0;
    cur   = DW'($urandom_range(0, 255));
    while (sent < 256 && guard < 30000) begin
      valid_in = 1'b1;
      data_in  = cur;
      acc      = ready_out;
      @(negedge clk_in);
      guard++;
      if (acc) begin
        exp_q.push_back(cur);
        sent++;
        cur = DW'($urandom_range(0, 255));
      end
    end
    valid_in = 1'b0;
    check("rand_sent", sent, 256);
    wait_idle("rand", 2000);
    repeat (R * 2) @(negedge clk_in);
    check("rand_frames", m_frames - frames0, 256);
    check("rand_queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
